// File: rtl/tow_referee.sv
// Tug of War match controller: arbitrates player presses into score-counter
// increments, sequences rounds, counts rounds won and declares the match winner.
module tow_referee #(
    parameter int ROUNDS_TO_WIN = 3,
    parameter int HOLD_CYCLES   = 8,
    localparam int CW           = $clog2(ROUNDS_TO_WIN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p1_press,
    input  logic          p2_press,
    input  logic          win1,
    input  logic          win2,
    output logic          inc1,
    output logic          inc2,
    output logic          clear,
    output logic          hold,
    output logic [CW-1:0] rounds1,
    output logic [CW-1:0] rounds2,
    output logic          match_over,
    output logic          match_winner
);

    typedef enum logic [2:0] {
        S_START      = 3'd0,
        S_CLEAR      = 3'd1,
        S_PLAY       = 3'd2,
        S_ROUND_END  = 3'd3,
        S_MATCH_OVER = 3'd4
    } state_t;

    localparam logic [CW-1:0] RTW_C     = CW'(ROUNDS_TO_WIN);
    localparam logic [7:0]    HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t        state_q, state_d;
    logic          pend1_q, pend1_d;
    logic          pend2_q, pend2_d;
    logic          last_grant_q, last_grant_d;   // 0 = player 1, 1 = player 2
    logic [CW-1:0] rounds1_q, rounds1_d;
    logic [CW-1:0] rounds2_q, rounds2_d;
    logic          round_winner_q, round_winner_d;
    logic          match_winner_q, match_winner_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic          grant1_s, grant2_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == RTW_C) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CW'(1);
        end
    endfunction

    // Round-robin grant: the player not served last wins a tie
    always_comb begin
        grant1_s = 1'b0;
        grant2_s = 1'b0;
        if (state_q == S_PLAY) begin
            if (pend1_q && (!pend2_q || last_grant_q)) begin
                grant1_s = 1'b1;
            end else if (pend2_q) begin
                grant2_s = 1'b1;
            end else begin
                grant1_s = 1'b0;
            end
        end else begin
            grant2_s = 1'b0;
        end
    end

    // Next-state, pending-press, round bookkeeping
    always_comb begin
        state_d        = state_q;
        pend1_d        = 1'b0;
        pend2_d        = 1'b0;
        last_grant_d   = last_grant_q;
        rounds1_d      = rounds1_q;
        rounds2_d      = rounds2_q;
        round_winner_d = round_winner_q;
        match_winner_d = match_winner_q;
        hold_cnt_d     = hold_cnt_q;
        case (state_q)
            S_START: begin
                if (p1_press || p2_press) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_START;
                end
            end
            S_CLEAR: begin
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (grant1_s) begin
                    last_grant_d = 1'b0;
                end else if (grant2_s) begin
                    last_grant_d = 1'b1;
                end else begin
                    last_grant_d = last_grant_q;
                end
                // A win discards anything pending, including presses this cycle
                if (win1 || win2) begin
                    state_d    = S_ROUND_END;
                    hold_cnt_d = HOLD_LOAD;
                    if (win1 && !win2) begin
                        rounds1_d      = sat_inc(rounds1_q);
                        round_winner_d = 1'b0;
                    end else if (win2 && !win1) begin
                        rounds2_d      = sat_inc(rounds2_q);
                        round_winner_d = 1'b1;
                    end else begin
                        round_winner_d = round_winner_q;
                    end
                end else begin
                    pend1_d = (pend1_q && !grant1_s) || p1_press;
                    pend2_d = (pend2_q && !grant2_s) || p2_press;
                end
            end
            S_ROUND_END: begin
                if (hold_cnt_q == 8'd0) begin
                    if ((rounds1_q == RTW_C) || (rounds2_q == RTW_C)) begin
                        state_d        = S_MATCH_OVER;
                        match_winner_d = round_winner_q;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            S_MATCH_OVER: begin
                state_d = S_MATCH_OVER;
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_START;
            pend1_q        <= 1'b0;
            pend2_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            rounds1_q      <= '0;
            rounds2_q      <= '0;
            round_winner_q <= 1'b0;
            match_winner_q <= 1'b0;
            hold_cnt_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            pend1_q        <= pend1_d;
            pend2_q        <= pend2_d;
            last_grant_q   <= last_grant_d;
            rounds1_q      <= rounds1_d;
            rounds2_q      <= rounds2_d;
            round_winner_q <= round_winner_d;
            match_winner_q <= match_winner_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign inc1         = grant1_s;
    assign inc2         = grant2_s;
    assign clear        = (state_q == S_CLEAR);
    assign hold         = (state_q != S_PLAY);
    assign match_over   = (state_q == S_MATCH_OVER);
    assign match_winner = match_winner_q;
    assign rounds1      = rounds1_q;
    assign rounds2      = rounds2_q;

endmodule

// File: tb/tb_tow_referee.sv
// Self-checking bench for tow_referee: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the match rules.
module tb_tow_referee;

    localparam int RTW  = 3;
    localparam int HOLD = 8;
    localparam int CW   = $clog2(RTW + 1);

    logic          clk = 1'b0;
    logic          reset, p1_press, p2_press, win1, win2;
    logic          inc1, inc2, clear, hold, match_over, match_winner;
    logic [CW-1:0] rounds1, rounds2;

    int errors = 0;
    int checks = 0;

    tow_referee #(.ROUNDS_TO_WIN(RTW), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .p1_press(p1_press), .p2_press(p2_press),
        .win1(win1), .win2(win2), .inc1(inc1), .inc2(inc2), .clear(clear),
        .hold(hold), .rounds1(rounds1), .rounds2(rounds2),
        .match_over(match_over), .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase names, waiting presses, who was served last
    typedef enum int {M_START, M_CLEAR, M_PLAY, M_REND, M_OVER} phase_t;
    phase_t m_phase;
    bit     m_want1, m_want2, m_last_p2, m_rw, m_winner;
    int     m_r1, m_r2, m_left;
    bit     chk_en = 1'b0;

    task automatic check1(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        bit e1, e2;
        e1 = (m_phase == M_PLAY) && m_want1 && (!m_want2 || m_last_p2);
        e2 = (m_phase == M_PLAY) && m_want2 && !e1;
        check1("inc1", int'(inc1), int'(e1));
        check1("inc2", int'(inc2), int'(e2));
        check1("hold", int'(hold), int'(m_phase != M_PLAY));
        check1("clear", int'(clear), int'(m_phase == M_CLEAR));
        check1("match_over", int'(match_over), int'(m_phase == M_OVER));
        check1("match_winner", int'(match_winner), int'(m_winner));
        check1("rounds1", int'(rounds1), m_r1);
        check1("rounds2", int'(rounds2), m_r2);
        check1("inc_exclusive", int'(inc1 & inc2), 0);
    endtask

    task automatic model_step(input bit a, input bit b, input bit w1, input bit w2, input bit r);
        bit g1, g2;
        g1 = (m_phase == M_PLAY) && m_want1 && (!m_want2 || m_last_p2);
        g2 = (m_phase == M_PLAY) && m_want2 && !g1;
        if (r) begin
            m_phase = M_START; m_want1 = 0; m_want2 = 0; m_last_p2 = 1;
            m_r1 = 0; m_r2 = 0; m_rw = 0; m_winner = 0; m_left = 0;
        end else begin
            case (m_phase)
                M_START: if (a || b) m_phase = M_CLEAR;
                M_CLEAR: m_phase = M_PLAY;
                M_PLAY: begin
                    if (g1) m_last_p2 = 0;
                    if (g2) m_last_p2 = 1;
                    if (w1 || w2) begin
                        if (w1 && !w2) begin
                            m_r1 = (m_r1 < RTW) ? m_r1 + 1 : RTW; m_rw = 0;
                        end
                        if (w2 && !w1) begin
                            m_r2 = (m_r2 < RTW) ? m_r2 + 1 : RTW; m_rw = 1;
                        end
                        m_phase = M_REND; m_left = HOLD;
                        m_want1 = 0; m_want2 = 0;
                    end else begin
                        m_want1 = (m_want1 && !g1) || a;
                        m_want2 = (m_want2 && !g2) || b;
                    end
                end
                M_REND: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_r1 == RTW || m_r2 == RTW) begin
                            m_phase = M_OVER; m_winner = m_rw;
                        end else begin
                            m_phase = M_CLEAR;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock: check current outputs, drive inputs, advance model at the edge
    task automatic cyc(input bit a, input bit b, input bit w1, input bit w2, input bit r);
        if (chk_en) check_all();
        p1_press = a; p2_press = b; win1 = w1; win2 = w2; reset = r;
        @(posedge clk);
        model_step(a, b, w1, w2, r);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic wait_play();
        int n;
        n = 0;
        while (m_phase != M_PLAY && n < 40) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        check1("wait_play_timeout", int'(m_phase == M_PLAY), 1);
    endtask

    initial begin
        reset = 1; p1_press = 0; p2_press = 0; win1 = 0; win2 = 0;
        @(negedge clk);
        cyc(0, 0, 0, 0, 1);
        chk_en = 1'b1;
        cyc(1, 1, 1, 1, 1);          // reset beats press and win
        idle(2);
        // START -> CLEAR on a press; the press yields no increment
        cyc(1, 0, 0, 0, 0);
        check1("clear_after_start", int'(clear), 1);
        idle(1);
        check1("play_hold_low", int'(hold), 0);
        idle(2);
        // Tie: player 1 first, then player 2
        cyc(1, 1, 0, 0, 0);
        check1("tie_first_p1", int'(inc1), 1);
        idle(1);
        check1("tie_second_p2", int'(inc2), 1);
        idle(2);
        // p2 held for three cycles
        cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
        idle(3);
        // win1 with presses during the hold
        cyc(0, 0, 1, 0, 0);
        check1("rounds1_after_win", int'(rounds1), 1);
        for (int i = 0; i < 8; i++) cyc(i[0], ~i[0], 0, 0, 0);
        check1("clear_after_hold", int'(clear), 1);
        idle(1);
        check1("play_after_round", int'(hold), 0);
        // Void round
        cyc(1, 0, 1, 1, 0);
        wait_play();
        // Three player-2 wins (two-cycle win pulses)
        for (int k = 0; k < 3; k++) begin
            wait_play();
            cyc(1, 1, 0, 1, 0);
            cyc(0, 1, 0, 1, 0);
        end
        idle(12);
        check1("match_over_p2", int'(match_over), 1);
        check1("match_winner_p2", int'(match_winner), 1);
        check1("rounds2_final", int'(rounds2), 3);
        for (int i = 0; i < 6; i++) cyc(1, 1, i[0], ~i[0], 0);
        // Reset mid-ROUND_END with a press
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        wait_play();
        cyc(0, 0, 1, 0, 0);
        idle(3);
        cyc(1, 1, 0, 0, 1);
        check1("reset_hold", int'(hold), 1);
        check1("reset_rounds1", int'(rounds1), 0);
        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit a, b, w1, w2, r;
            a  = ($urandom_range(0, 2) == 0);
            b  = ($urandom_range(0, 2) == 0);
            w1 = ($urandom_range(0, 29) == 0);
            w2 = ($urandom_range(0, 29) == 0);
            r  = ($urandom_range(0, 599) == 0);
            cyc(a, b, w1, w2, r);
        end
        check_all();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
